fila_param: RTL and testbench

- Parametrised circular-buffer FIFO. Replaces the fixed 8x8 shift-register queue.
- Sits between the user-input front end (debounced buttons or switches) and the display/transmit path, all on clk_10KHz.
- Adds configurable width and depth, single-cycle enqueue/dequeue, simultaneous push/pop, and optional edge-triggered requests.
- Adds full/empty/valid flags, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/fila_param_if.sv | 27 ++
 rtl/fila_param.sv | 120 ++++++++++++
 tb/tb_fila_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fila_param_if.sv
// rtl/fila_param_if.sv - request/flag bundle between the input front end and the FIFO
interface fila_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) ();
    logic                     clear_in;
    logic [WIDTH-1:0]         data_in;
    logic                     enqueue_in;
    logic                     dequeue_in;
    logic [WIDTH-1:0]         data_out;
    logic                     data_valid;
    logic [$clog2(DEPTH):0]   len_out;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output clear_in, data_in, enqueue_in, dequeue_in,
        input  data_out, data_valid, len_out, full, empty, overflow, underflow
    );

    modport slave (
        input  clear_in, data_in, enqueue_in, dequeue_in,
        output data_out, data_valid, len_out, full, empty, overflow, underflow
    );
endinterface

// File: rtl/fila_param.sv
// rtl/fila_param.sv - parametrised circular-buffer FIFO with edge/level requests and sticky error flags
module fila_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int EDGE_MODE = 1
) (
    input  logic           clk_10KHz,
    input  logic           reset,
    fila_param_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             enq_q, enq_d;
    logic             deq_q, deq_d;

    logic push_req, pop_req, push_ok, pop_ok;

    always_comb begin
        push_req = bus.enqueue_in;
        pop_req  = bus.dequeue_in;
        if (EDGE_MODE != 0) begin
            push_req = bus.enqueue_in & ~enq_q;
            pop_req  = bus.dequeue_in & ~deq_q;
        end
        pop_ok  = pop_req & (count_q != '0);
        // A full FIFO still takes a push when the same edge frees a slot.
        push_ok = push_req & ((count_q < DEPTH_C) | pop_ok);
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        enq_d        = bus.enqueue_in;
        deq_d        = bus.dequeue_in;

        if (bus.clear_in) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            data_out_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = bus.data_in;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                data_out_d   = mem_q[rd_ptr_q];
                rd_ptr_d     = rd_ptr_q + AW'(1);
                data_valid_d = 1'b1;
            end
            if (push_req & ~push_ok) begin
                overflow_d = 1'b1;
            end
            if (pop_req & ~pop_ok) begin
                underflow_d = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            enq_q        <= 1'b0;
            deq_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            enq_q        <= enq_d;
            deq_q        <= deq_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_10KHz) begin
        mem_q <= mem_d;
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.len_out    = count_q;
    assign bus.full       = (count_q == DEPTH_C);
    assign bus.empty      = (count_q == '0);
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_fila_param.sv
// tb/tb_fila_param.sv - directed scoreboard bench for fila_param (8x8 edge, 8x8 level, 4x4 edge)
module tb_fila_param;
    logic clk_10KHz = 1'b0;
    logic reset;
    always #5 clk_10KHz = ~clk_10KHz;

    fila_param_if #(.WIDTH(8), .DEPTH(8)) if_a ();
    fila_param_if #(.WIDTH(8), .DEPTH(8)) if_l ();
    fila_param_if #(.WIDTH(4), .DEPTH(4)) if_s ();

    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1)) u_edge (
        .clk_10KHz(clk_10KHz), .reset(reset), .bus(if_a.slave));
    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(0)) u_level (
        .clk_10KHz(clk_10KHz), .reset(reset), .bus(if_l.slave));
    fila_param #(.WIDTH(4), .DEPTH(4), .EDGE_MODE(1)) u_small (
        .clk_10KHz(clk_10KHz), .reset(reset), .bus(if_s.slave));

    int         sel;
    logic       clr, enq, deq;
    logic [7:0] din;
    logic [7:0] o_data, o_len;
    logic       o_valid, o_full, o_empty, o_ovf, o_udf;

    assign if_a.clear_in   = (sel == 0) && clr;
    assign if_a.enqueue_in = (sel == 0) && enq;
    assign if_a.dequeue_in = (sel == 0) && deq;
    assign if_a.data_in    = din;
    assign if_l.clear_in   = (sel == 1) && clr;
    assign if_l.enqueue_in = (sel == 1) && enq;
    assign if_l.dequeue_in = (sel == 1) && deq;
    assign if_l.data_in    = din;
    assign if_s.clear_in   = (sel == 2) && clr;
    assign if_s.enqueue_in = (sel == 2) && enq;
    assign if_s.dequeue_in = (sel == 2) && deq;
    assign if_s.data_in    = din[3:0];

    always_comb begin
        o_data = if_a.data_out;  o_valid = if_a.data_valid; o_len = 8'(if_a.len_out);
        o_full = if_a.full;      o_empty = if_a.empty;
        o_ovf  = if_a.overflow;  o_udf   = if_a.underflow;
        if (sel == 1) begin
            o_data = if_l.data_out;  o_valid = if_l.data_valid; o_len = 8'(if_l.len_out);
            o_full = if_l.full;      o_empty = if_l.empty;
            o_ovf  = if_l.overflow;  o_udf   = if_l.underflow;
        end else if (sel == 2) begin
            o_data = 8'(if_s.data_out); o_valid = if_s.data_valid; o_len = 8'(if_s.len_out);
            o_full = if_s.full;         o_empty = if_s.empty;
            o_ovf  = if_s.overflow;     o_udf   = if_s.underflow;
        end
    end

    logic [7:0] exp_q [$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        compared++;
        assert (obs === req) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    // Advance one clock; any data_valid seen is checked against the scoreboard.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk_10KHz);
        @(negedge clk_10KHz);
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_without_expected_pop", 32'(o_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(o_data), 32'(e));
            end
        end
    endtask

    task automatic push_pulse(input logic [7:0] d);
        din = d; enq = 1'b1; tick();
        enq = 1'b0; tick();
    endtask

    task automatic pop_pulse(input logic [7:0] e);
        exp_q.push_back(e);
        deq = 1'b1; tick();
        deq = 1'b0; tick();
    endtask

    task automatic do_clear();
        clr = 1'b1; tick();
        clr = 1'b0; tick();
    endtask

    initial begin
        sel = 0; clr = 1'b0; enq = 1'b0; deq = 1'b0; din = 8'h00; reset = 1'b1;
        tick(); tick();
        chk("rst_len", 32'(o_len), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_udf", 32'(o_udf), 0);
        reset = 1'b0;
        tick();

        push_pulse(8'h11); push_pulse(8'h22); push_pulse(8'h33);
        chk("basic_len3", 32'(o_len), 3);
        chk("basic_not_empty", 32'(o_empty), 0);
        pop_pulse(8'h11);
        chk("valid_one_cycle", 32'(o_valid), 0);
        pop_pulse(8'h22); pop_pulse(8'h33);
        chk("basic_len0", 32'(o_len), 0);
        chk("basic_empty", 32'(o_empty), 1);
        chk("basic_sb_drained", 32'(exp_q.size()), 0);

        deq = 1'b1; tick();
        chk("udf_no_valid", 32'(o_valid), 0);
        deq = 1'b0; tick();
        chk("udf_set", 32'(o_udf), 1);
        chk("udf_data_held", 32'(o_data), 32'h33);
        do_clear();
        chk("clr_udf", 32'(o_udf), 0);
        chk("clr_data", 32'(o_data), 0);

        for (int i = 0; i < 8; i++) push_pulse(8'hA0 + 8'(i));
        push_pulse(8'hFF);
        chk("ovf_full", 32'(o_full), 1);
        chk("ovf_len8", 32'(o_len), 8);
        chk("ovf_set", 32'(o_ovf), 1);
        for (int i = 0; i < 8; i++) pop_pulse(8'hA0 + 8'(i));
        chk("ovf_drain_len0", 32'(o_len), 0);
        chk("ovf_sb_drained", 32'(exp_q.size()), 0);
        do_clear();
        chk("clr_ovf", 32'(o_ovf), 0);

        for (int i = 0; i < 8; i++) push_pulse(8'hA0 + 8'(i));
        exp_q.push_back(8'hA0);
        din = 8'hB0; enq = 1'b1; deq = 1'b1; tick();
        enq = 1'b0; deq = 1'b0; tick();
        chk("fullpp_len8", 32'(o_len), 8);
        chk("fullpp_no_ovf", 32'(o_ovf), 0);
        chk("fullpp_data", 32'(o_data), 32'hA0);
        for (int i = 1; i < 8; i++) pop_pulse(8'hA0 + 8'(i));
        pop_pulse(8'hB0);
        chk("wrap_sb_drained", 32'(exp_q.size()), 0);
        chk("wrap_empty", 32'(o_empty), 1);

        din = 8'h5A; enq = 1'b1;
        repeat (20) tick();
        chk("edge_hold_len1", 32'(o_len), 1);
        enq = 1'b0; tick();
        do_clear();

        sel = 1; tick();
        din = 8'h5A; enq = 1'b1;
        repeat (20) tick();
        enq = 1'b0; tick();
        chk("level_len8", 32'(o_len), 8);
        chk("level_full", 32'(o_full), 1);
        chk("level_ovf", 32'(o_ovf), 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h5A);
        deq = 1'b1;
        repeat (8) tick();
        deq = 1'b0; tick();
        chk("level_drain_empty", 32'(o_empty), 1);
        chk("level_no_udf", 32'(o_udf), 0);
        chk("level_sb_drained", 32'(exp_q.size()), 0);

        sel = 0; tick();
        for (int i = 0; i < 6; i++) push_pulse(8'hD0 + 8'(i));
        pop_pulse(8'hD0);
        chk("pre_rst_len5", 32'(o_len), 5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_len", 32'(o_len), 0);
        chk("async_rst_empty", 32'(o_empty), 1);
        chk("async_rst_data", 32'(o_data), 0);
        @(negedge clk_10KHz);
        reset = 1'b0;
        din = 8'hC0; enq = 1'b1; deq = 1'b1; tick();
        enq = 1'b0; deq = 1'b0; tick();
        chk("post_rst_pp_len1", 32'(o_len), 1);
        chk("post_rst_pp_udf", 32'(o_udf), 1);
        pop_pulse(8'hC0);
        chk("post_rst_empty", 32'(o_empty), 1);
        chk("post_rst_sb_drained", 32'(exp_q.size()), 0);

        sel = 2; tick();
        push_pulse(8'h01); push_pulse(8'h02); push_pulse(8'h03);
        chk("small_len3", 32'(o_len), 3);
        pop_pulse(8'h01); pop_pulse(8'h02); pop_pulse(8'h03);
        chk("small_empty", 32'(o_empty), 1);
        for (int i = 4; i < 8; i++) push_pulse(8'(i));
        push_pulse(8'h0F);
        chk("small_full", 32'(o_full), 1);
        chk("small_len4", 32'(o_len), 4);
        chk("small_ovf", 32'(o_ovf), 1);
        for (int i = 4; i < 8; i++) pop_pulse(8'(i));
        chk("small_sb_drained", 32'(exp_q.size()), 0);
        chk("small_drain_empty", 32'(o_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
